// File: rtl/cnn_layer_accel_job_ctrl.sv
// Quad-side job controller: accepts a job, decodes the layer configuration,
// handshakes the fetch, sequences output-tensor positions and reports completion.
module cnn_layer_accel_job_ctrl (
  input  logic         clk_core,
  input  logic         rst,
  input  logic         job_start,
  output logic         job_accept,
  input  logic [127:0] job_parameters,
  output logic         job_fetch_request,
  input  logic         job_fetch_ack,
  input  logic         job_fetch_complete,
  output logic         job_complete,
  input  logic         job_complete_ack,
  input  logic         out_step,
  output logic [9:0]   num_output_rows_cfg,
  output logic [9:0]   num_output_cols_cfg,
  output logic [6:0]   num_kernel_cfg,
  output logic [4:0]   kernel_size_cfg,
  output logic [6:0]   convolution_stride_cfg,
  output logic [4:0]   padding_cfg,
  output logic [9:0]   output_row,
  output logic [9:0]   output_col,
  output logic [6:0]   output_depth,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        cfg_load;

  logic [9:0]  rows_q, cols_q;
  logic [6:0]  kern_q;
  logic [4:0]  ksize_q;
  logic [6:0]  stride_q;
  logic [4:0]  pad_q;

  logic [9:0]  row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic [6:0]  dep_q, dep_d;

  logic [9:0]  rows_m1, cols_m1;
  logic [6:0]  kern_m1;
  logic        zero_size;

  // Descriptor bits above the padding field carry nothing for this block.
  logic        unused_param_bits;
  assign unused_param_bits = ^job_parameters[127:44];

  assign rows_m1   = rows_q - 10'd1;
  assign cols_m1   = cols_q - 10'd1;
  assign kern_m1   = kern_q - 7'd1;
  assign zero_size = (rows_q == '0) || (cols_q == '0) || (kern_q == '0);

  always_comb begin
    state_d  = state_q;
    cfg_load = 1'b0;
    row_d    = '0;
    col_d    = '0;
    dep_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          cfg_load = 1'b1;
          state_d  = S_ACCEPT;
        end
      end
      S_ACCEPT: state_d = S_FETCH_REQ;
      S_FETCH_REQ: begin
        if (job_fetch_ack) begin
          if (job_fetch_complete) state_d = zero_size ? S_DONE : S_COMPUTE;
          else                    state_d = S_FETCH_WAIT;
        end
      end
      S_FETCH_WAIT: begin
        if (job_fetch_complete) state_d = zero_size ? S_DONE : S_COMPUTE;
      end
      S_COMPUTE: begin
        row_d = row_q;
        col_d = col_q;
        dep_d = dep_q;
        // Depth is innermost, then column, then row; the last step leaves all at zero.
        if (out_step) begin
          if (dep_q == kern_m1) begin
            dep_d = '0;
            if (col_q == cols_m1) begin
              col_d = '0;
              if (row_q == rows_m1) begin
                row_d   = '0;
                state_d = S_DONE;
              end else begin
                row_d = row_q + 10'd1;
              end
            end else begin
              col_d = col_q + 10'd1;
            end
          end else begin
            dep_d = dep_q + 7'd1;
          end
        end
      end
      S_DONE: begin
        if (job_complete_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      dep_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dep_q   <= dep_d;
    end
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      rows_q   <= '0;
      cols_q   <= '0;
      kern_q   <= '0;
      ksize_q  <= '0;
      stride_q <= '0;
      pad_q    <= '0;
    end else if (cfg_load) begin
      rows_q   <= job_parameters[9:0];
      cols_q   <= job_parameters[19:10];
      kern_q   <= job_parameters[26:20];
      ksize_q  <= job_parameters[31:27];
      stride_q <= job_parameters[38:32];
      pad_q    <= job_parameters[43:39];
    end
  end

  assign job_accept        = (state_q == S_ACCEPT);
  assign job_fetch_request = (state_q == S_FETCH_REQ);
  assign job_complete      = (state_q == S_DONE);
  assign busy              = (state_q != S_IDLE);

  assign num_output_rows_cfg    = rows_q;
  assign num_output_cols_cfg    = cols_q;
  assign num_kernel_cfg         = kern_q;
  assign kernel_size_cfg        = ksize_q;
  assign convolution_stride_cfg = stride_q;
  assign padding_cfg            = pad_q;

  assign output_row   = row_q;
  assign output_col   = col_q;
  assign output_depth = dep_q;

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Bench for cnn_layer_accel_job_ctrl: table-driven basic job, then hand-written
// handshake, zero-size, simultaneous-fetch and reset corner cases.
module tb_cnn_layer_accel_job_ctrl;

  logic         clk_core = 1'b0;
  logic         rst;
  logic         job_start;
  logic         job_accept;
  logic [127:0] job_parameters;
  logic         job_fetch_request;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack;
  logic         out_step;
  logic [9:0]   num_output_rows_cfg;
  logic [9:0]   num_output_cols_cfg;
  logic [6:0]   num_kernel_cfg;
  logic [4:0]   kernel_size_cfg;
  logic [6:0]   convolution_stride_cfg;
  logic [4:0]   padding_cfg;
  logic [9:0]   output_row;
  logic [9:0]   output_col;
  logic [6:0]   output_depth;
  logic         busy;

  cnn_layer_accel_job_ctrl dut (
    .clk_core               (clk_core),
    .rst                    (rst),
    .job_start              (job_start),
    .job_accept             (job_accept),
    .job_parameters         (job_parameters),
    .job_fetch_request      (job_fetch_request),
    .job_fetch_ack          (job_fetch_ack),
    .job_fetch_complete     (job_fetch_complete),
    .job_complete           (job_complete),
    .job_complete_ack       (job_complete_ack),
    .out_step               (out_step),
    .num_output_rows_cfg    (num_output_rows_cfg),
    .num_output_cols_cfg    (num_output_cols_cfg),
    .num_kernel_cfg         (num_kernel_cfg),
    .kernel_size_cfg        (kernel_size_cfg),
    .convolution_stride_cfg (convolution_stride_cfg),
    .padding_cfg            (padding_cfg),
    .output_row             (output_row),
    .output_col             (output_col),
    .output_depth           (output_depth),
    .busy                   (busy)
  );

  always #5 clk_core = ~clk_core;

  typedef struct packed {
    logic       acc;
    logic       freq;
    logic       comp;
    logic       busy;
    logic [9:0] row;
    logic [9:0] col;
    logic [6:0] dep;
  } exp_t;

  typedef struct {
    logic  start;
    logic  fack;
    logic  fcomp;
    logic  cack;
    logic  ostep;
    exp_t  exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] mk(input int r, input int c, input int k,
                                      input int ks, input int s, input int p);
    logic [127:0] v;
    v = '0;
    v[127:96] = 32'hDEAD_BEEF;
    v[63:44]  = 20'hABCDE;
    v[9:0]    = r[9:0];
    v[19:10]  = c[9:0];
    v[26:20]  = k[6:0];
    v[31:27]  = ks[4:0];
    v[38:32]  = s[6:0];
    v[43:39]  = p[4:0];
    return v;
  endfunction

  function automatic exp_t ex(input logic a, input logic f, input logic c, input logic b,
                              input int r, input int co, input int d);
    exp_t e;
    e.acc = a; e.freq = f; e.comp = c; e.busy = b;
    e.row = r[9:0]; e.col = co[9:0]; e.dep = d[6:0];
    return e;
  endfunction

  task automatic drive(input logic st, input logic fa, input logic fc,
                       input logic ca, input logic os);
    job_start = st; job_fetch_ack = fa; job_fetch_complete = fc;
    job_complete_ack = ca; out_step = os;
  endtask

  task automatic push(input logic a, input logic f, input logic c, input logic b,
                      input int r, input int co, input int d);
    sb.push_back(ex(a, f, c, b, r, co, d));
  endtask

  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clk_core);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_accept"}, {31'd0, job_accept}, {31'd0, e.acc});
      chk({tag, "_freq"},   {31'd0, job_fetch_request}, {31'd0, e.freq});
      chk({tag, "_comp"},   {31'd0, job_complete}, {31'd0, e.comp});
      chk({tag, "_busy"},   {31'd0, busy}, {31'd0, e.busy});
      chk({tag, "_pos"},    {5'd0, output_row, output_col, output_depth},
                            {5'd0, e.row, e.col, e.dep});
    end
  endtask

  task automatic chk_cfg(input string tag, input logic [127:0] p);
    chk({tag, "_rows"},   {22'd0, num_output_rows_cfg},   {22'd0, p[9:0]});
    chk({tag, "_cols"},   {22'd0, num_output_cols_cfg},   {22'd0, p[19:10]});
    chk({tag, "_kern"},   {25'd0, num_kernel_cfg},        {25'd0, p[26:20]});
    chk({tag, "_ksize"},  {27'd0, kernel_size_cfg},       {27'd0, p[31:27]});
    chk({tag, "_stride"}, {25'd0, convolution_stride_cfg},{25'd0, p[38:32]});
    chk({tag, "_pad"},    {27'd0, padding_cfg},           {27'd0, p[43:39]});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {28'd0, job_accept, job_fetch_request, job_complete, busy}, 32'd0);
    chk({tag, "_pos"}, {5'd0, output_row, output_col, output_depth}, 32'd0);
    chk_cfg(tag, '0);
  endtask

  logic [127:0] p1, p2, p3, pz;

  initial begin
    p1 = mk(2, 2, 3, 3, 1, 1);
    p2 = mk(1, 2, 2, 5, 2, 2);
    p3 = mk(3, 1, 1, 7, 4, 0);
    pz = mk(0, 2, 2, 1, 1, 0);

    // Basic job 2x2x3: ack one cycle after request, complete one cycle after ack.
    tbl[0] = '{1, 0, 0, 0, 0, ex(1, 0, 0, 1, 0, 0, 0)};
    tbl[1] = '{0, 0, 0, 0, 0, ex(0, 1, 0, 1, 0, 0, 0)};
    tbl[2] = '{0, 1, 0, 0, 0, ex(0, 0, 0, 1, 0, 0, 0)};
    tbl[3] = '{0, 0, 1, 0, 0, ex(0, 0, 0, 1, 0, 0, 0)};
    for (int j = 1; j <= 11; j++)
      tbl[3 + j] = '{0, 0, 0, 0, 1, ex(0, 0, 0, 1, j / 6, (j / 3) % 2, j % 3)};
    tbl[15] = '{0, 0, 0, 0, 1, ex(0, 0, 1, 1, 0, 0, 0)};
    tbl[16] = '{0, 0, 0, 0, 0, ex(0, 0, 1, 1, 0, 0, 0)};
    tbl[17] = '{0, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)};

    rst = 1'b1;
    job_parameters = '0;
    drive(0, 0, 0, 0, 0);
    #12;
    chk_all_zero("reset");
    @(posedge clk_core);
    #1;
    rst = 1'b0;

    job_parameters = p1;
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].start, tbl[i].fack, tbl[i].fcomp, tbl[i].cack, tbl[i].ostep);
      sb.push_back(tbl[i].exp);
      tick_check($sformatf("vec%0d", i));
      if (i == 0) chk_cfg("basic_cfg", p1);
    end
    drive(0, 0, 0, 0, 0);

    // Held fetch ack, out_step in IDLE/FETCH_WAIT, start during COMPUTE, held complete ack.
    job_parameters = p2;
    drive(1, 0, 0, 0, 1); push(1, 0, 0, 1, 0, 0, 0); tick_check("h_accept");
    chk_cfg("h_cfg", p2);
    drive(0, 0, 0, 0, 0); push(0, 1, 0, 1, 0, 0, 0); tick_check("h_req0");
    for (int i = 0; i < 4; i++) begin
      push(0, 1, 0, 1, 0, 0, 0); tick_check($sformatf("h_req%0d", i + 1));
    end
    drive(0, 1, 0, 0, 0); push(0, 0, 0, 1, 0, 0, 0); tick_check("h_ack");
    drive(0, 0, 0, 0, 1); push(0, 0, 0, 1, 0, 0, 0); tick_check("h_wait0");
    push(0, 0, 0, 1, 0, 0, 0); tick_check("h_wait1");
    drive(0, 0, 1, 0, 1); push(0, 0, 0, 1, 0, 0, 0); tick_check("h_enter");
    job_parameters = p1;
    drive(1, 0, 0, 0, 0); push(0, 0, 0, 1, 0, 0, 0); tick_check("h_start_ign");
    chk_cfg("h_cfg_hold", p2);
    drive(0, 0, 0, 0, 1);
    push(0, 0, 0, 1, 0, 0, 1); tick_check("h_s1");
    push(0, 0, 0, 1, 0, 1, 0); tick_check("h_s2");
    push(0, 0, 0, 1, 0, 1, 1); tick_check("h_s3");
    push(0, 0, 1, 1, 0, 0, 0); tick_check("h_s4");
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 1, 1, 0, 0, 0); tick_check($sformatf("h_done%0d", i));
    end
    drive(0, 0, 0, 1, 0); push(0, 0, 0, 0, 0, 0, 0); tick_check("h_idle");
    chk_cfg("h_cfg_after", p2);

    // Zero-size job goes from FETCH_WAIT straight to DONE.
    job_parameters = pz;
    drive(1, 0, 0, 0, 0); push(1, 0, 0, 1, 0, 0, 0); tick_check("z_accept");
    drive(0, 0, 0, 0, 0); push(0, 1, 0, 1, 0, 0, 0); tick_check("z_req");
    drive(0, 1, 0, 0, 0); push(0, 0, 0, 1, 0, 0, 0); tick_check("z_wait");
    drive(0, 0, 1, 0, 0); push(0, 0, 1, 1, 0, 0, 0); tick_check("z_done");
    chk_cfg("z_cfg", pz);
    drive(0, 0, 0, 1, 0); push(0, 0, 0, 0, 0, 0, 0); tick_check("z_idle");

    // Simultaneous ack and complete skip FETCH_WAIT; reset lands at (0,1,1).
    job_parameters = p1;
    drive(1, 0, 0, 0, 0); push(1, 0, 0, 1, 0, 0, 0); tick_check("s_accept");
    drive(0, 0, 0, 0, 0); push(0, 1, 0, 1, 0, 0, 0); tick_check("s_req");
    drive(0, 1, 1, 0, 0); push(0, 0, 0, 1, 0, 0, 0); tick_check("s_compute");
    drive(0, 0, 0, 0, 1);
    push(0, 0, 0, 1, 0, 0, 1); tick_check("s_s1");
    push(0, 0, 0, 1, 0, 0, 2); tick_check("s_s2");
    push(0, 0, 0, 1, 0, 1, 0); tick_check("s_s3");
    push(0, 0, 0, 1, 0, 1, 1); tick_check("s_s4");
    drive(0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    #2;
    rst = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0); tick_check("r_idle");

    // Fresh 3x1x1 job after reset: each step advances the row.
    job_parameters = p3;
    drive(1, 0, 0, 0, 0); push(1, 0, 0, 1, 0, 0, 0); tick_check("n_accept");
    drive(0, 0, 0, 0, 0); push(0, 1, 0, 1, 0, 0, 0); tick_check("n_req");
    drive(0, 1, 0, 0, 0); push(0, 0, 0, 1, 0, 0, 0); tick_check("n_wait");
    drive(0, 0, 1, 0, 0); push(0, 0, 0, 1, 0, 0, 0); tick_check("n_compute");
    chk_cfg("n_cfg", p3);
    drive(0, 0, 0, 0, 1);
    push(0, 0, 0, 1, 1, 0, 0); tick_check("n_s1");
    push(0, 0, 0, 1, 2, 0, 0); tick_check("n_s2");
    push(0, 0, 1, 1, 0, 0, 0); tick_check("n_s3");
    drive(0, 0, 0, 1, 0); push(0, 0, 0, 0, 0, 0, 0); tick_check("n_idle");
    drive(0, 0, 0, 1, 1); push(0, 0, 0, 0, 0, 0, 0); tick_check("n_idle_ign");
    drive(0, 0, 0, 0, 0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
